// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected array result path.
// No logic of its own: widths, FSM state encoding, saturation bounds, column priority helper.
package fc_pkg;

    localparam int ACC_W = 44;
    localparam int RES_W = 8;
    localparam int NCOL  = 4;
    localparam int EXT_W = ACC_W + 1;

    localparam int RES_MAX = 127;
    localparam int RES_MIN = -128;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set (callers check |v separately).
    function automatic logic [1:0] lowest_set(input logic [NCOL-1:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantizes a 44-bit signed accumulator to 8 bits: round half up, arithmetic shift, saturate.
// Purely combinational (zero latency, no backpressure); FC_COLLECT_RELU_EN clamps negatives to 0.
module fc_requant
    import fc_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic [5:0]       i_shift,
    output logic [RES_W-1:0] o_res
);

    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(RES_MAX);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(RES_MIN);

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_bias;
    logic signed [EXT_W-1:0] w_t;
    logic        [RES_W-1:0] w_sat;

    always_comb begin
        w_ext  = $signed({i_acc[ACC_W-1], i_acc});
        w_bias = '0;
        // One extra bit of headroom keeps acc + half-LSB from overflowing at any legal shift.
        if (i_shift != 6'd0) begin
            w_bias = $signed(EXT_W'(1) << (i_shift - 6'd1));
        end
        w_t = (w_ext + w_bias) >>> i_shift;

        if (w_t > SAT_HI) begin
            w_sat = RES_W'(RES_MAX);
        end else if (w_t < SAT_LO) begin
            w_sat = RES_W'(RES_MIN);
        end else begin
            w_sat = w_t[RES_W-1:0];
        end

`ifdef FC_COLLECT_RELU_EN
        if (w_sat[RES_W-1]) begin
            w_sat = '0;
        end
`endif
        o_res = w_sat;
    end

endmodule

// File: rtl/fc_result_collector.sv
// Captures the four column accumulators on done and streams requantized unmasked columns (FC_COLLECT_RELU_EN: ReLU).
// Latency: first beat valid the cycle after done; backpressure: beats hold while res_ready is low, done while busy is dropped.
module fc_result_collector
    import fc_pkg::*;
#(
    parameter int SHIFT_L0 = 12,
    parameter int SHIFT_L1 = 10,
    parameter int SHIFT_L2 = 10,
    parameter int SHIFT_L3 = 8
) (
    input  logic             clk,
    input  logic             rst_fsm,
    input  logic             done,
    input  logic [1:0]       layer_fc,
    input  logic [NCOL-1:0]  ckg_cmask,
    input  logic [ACC_W-1:0] o_data1,
    input  logic [ACC_W-1:0] o_data2,
    input  logic [ACC_W-1:0] o_data3,
    input  logic [ACC_W-1:0] o_data4,
    output logic [RES_W-1:0] res_data,
    output logic [1:0]       res_col,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_last,
    output logic             busy,
    output logic             drop_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [ACC_W-1:0] r_hold [NCOL];
    logic [5:0]       r_shift;
    logic [5:0]       w_shift_in;
    logic [NCOL-1:0]  r_mask;
    logic [NCOL-1:0]  w_live_in;
    logic [NCOL-1:0]  w_above;
    logic             w_capture;
    logic             w_last;
    logic             w_busy;
    logic             r_drop_err;
    logic [ACC_W-1:0] w_sel;
    logic [RES_W-1:0] w_res;

    always_comb begin
        unique case (layer_fc)
            2'd0:    w_shift_in = 6'(SHIFT_L0);
            2'd1:    w_shift_in = 6'(SHIFT_L1);
            2'd2:    w_shift_in = 6'(SHIFT_L2);
            default: w_shift_in = 6'(SHIFT_L3);
        endcase
    end

    assign w_live_in = ~ckg_cmask;
    // Unmasked columns strictly above the current index.
    assign w_above   = ~r_mask & (4'b1110 << r_idx);
    assign w_last    = ~(|w_above);
    assign w_busy    = (r_state == S_EMIT);
    assign w_sel     = r_hold[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (done) begin
                    w_capture = 1'b1;
                    if (|w_live_in) begin
                        w_state_nxt = S_EMIT;
                        w_idx_nxt   = lowest_set(w_live_in);
                    end
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = lowest_set(w_above);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_fsm) begin
        if (!rst_fsm) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_shift    <= '0;
            r_mask     <= '0;
            r_drop_err <= 1'b0;
            for (int i = 0; i < NCOL; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            // Pre-edge state decides, so a done on the final handshake edge is also dropped.
            if (done && w_busy) begin
                r_drop_err <= 1'b1;
            end
            if (w_capture) begin
                r_hold[0] <= o_data1;
                r_hold[1] <= o_data2;
                r_hold[2] <= o_data3;
                r_hold[3] <= o_data4;
                r_shift   <= w_shift_in;
                r_mask    <= ckg_cmask;
            end
        end
    end

    fc_requant u_requant (
        .i_acc   (w_sel),
        .i_shift (r_shift),
        .o_res   (w_res)
    );

    assign res_data  = w_res;
    assign res_col   = r_idx;
    assign res_valid = w_busy;
    assign res_last  = w_busy & w_last;
    assign busy      = w_busy;
    assign drop_err  = r_drop_err;

endmodule

// File: doc/fc_result_collector.md
# fc_result_collector

Output-side counterpart of the 4x4 fully-connected array: it receives the four 44-bit column accumulators when the array finishes a layer pass, requantizes each to signed 8 bits, and streams the results out over a valid/ready interface. It sits between `fully_connected_all` and the next layer's data buffer, replacing the bench-side result consumer with synthesizable logic.

## Interface
Parameters:
- `SHIFT_L0`, default 12: right-shift for `layer_fc`=0.
- `SHIFT_L1`, default 10: right-shift for `layer_fc`=1.
- `SHIFT_L2`, default 10: right-shift for `layer_fc`=2.
- `SHIFT_L3`, default 8: right-shift for `layer_fc`=3.
- Legal shift range for all four is 0..43.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_fsm` in 1: reset, asynchronous, active-low.
- `done` in 1: one-cycle pulse; `o_data1..4` are valid in that cycle.
- `layer_fc` in 2: selects the shift; sampled with `done`.
- `ckg_cmask` in 4: a set bit means that column is gated and produces no output; sampled with `done`.
- `o_data1`..`o_data4` in 44 each: signed two's-complement column accumulators.
- `res_data` out 8: signed requantized result.
- `res_col` out 2: column index of `res_data` (0 means `o_data1`).
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_last` out 1: marks the final result of the pass.
- `busy` out 1: high when not IDLE.
- `drop_err` out 1: sticky; a `done` arrived while busy.

## Operation
- States are IDLE and EMIT.
- IDLE:
  - On `done`=1, capture `o_data1..4` into holding registers. Also capture the shift for `layer_fc` and capture `ckg_cmask`.
  - If any column is unmasked, go to EMIT with `idx` set to the lowest unmasked column.
  - If all four columns are masked, stay in IDLE and emit nothing.
- EMIT:
  - `res_valid`=1. `res_data` is the requantized value of `hold[idx]`, `res_col`=`idx`.
  - `res_last`=1 when no unmasked column lies above `idx`.
  - On `res_valid && res_ready`: if `res_last`, go to IDLE; else `idx` becomes the next unmasked column.
- Requantization, computed in 45-bit signed arithmetic:
  - If shift>0, `t = (acc + (1<<(sh-1))) >>> sh`, i.e. round half toward +inf. If shift=0, `t = acc`.
  - Saturate `t` to the range -128..127.
- `done` while in EMIT: the pulse is ignored, holding registers are unchanged, and `drop_err` is set. `drop_err` is cleared only by reset.
- A `done` pulse on the same edge that the final handshake completes is also dropped and sets `drop_err`. The state check uses the pre-edge state.
- Reset values:
  - state=IDLE, `idx`=0, holding registers=0.
  - `res_valid`=0, `res_last`=0, `res_data`=0, `res_col`=0.
  - `busy`=0, `drop_err`=0.
- Reset mid-EMIT aborts the pass immediately. No further beat is emitted.

## Timing
- Latency: `done` sampled at edge k, so `res_valid` is high from after edge k until the handshake edge.
- One beat per cycle while `res_ready`=1. An unmasked pass of N columns completes in N cycles with no gaps.
- `res_data`, `res_col` and `res_last` are held stable while `res_valid && !res_ready`.
- `res_valid` never depends combinationally on `res_ready`.
- `busy` equals (state==EMIT).

## Configuration
- `FC_COLLECT_RELU_EN` defined: after saturation, negative results are forced to 0, giving a range of 0..127.
- `FC_COLLECT_RELU_EN` undefined: full signed range -128..127 is output.
- `res_last`, masking and handshake behaviour are identical in both builds.

## Structure
- Shared package `fc_pkg` holds:
  - `ACC_W`=44, `RES_W`=8, `NCOL`=4.
  - The state enum `{S_IDLE, S_EMIT}`.
  - `RES_MAX`=127 and `RES_MIN`=-128.
- One sub-module, `fc_requant`: purely combinational round/shift/saturate (and the optional ReLU), taking a 44-bit value and a 6-bit shift and returning 8 bits.
- The FSM, holding registers and next-unmasked-column priority logic live in the top level.

## Test plan
- Rounding, normal range:
  - Stimulus: `layer_fc`=0, mask 0000, `res_ready`=1. `o_data1..4` = 14336, -14336, 2047, 0.
  - Required: beats are 4, -3, 0, 0 on cols 0..3 in 4 consecutive cycles; `res_last` only on col 3.
- Saturation:
  - Stimulus: `layer_fc`=3 (shift 8), `o_data1`=1048576, `o_data2`=-1048576.
  - Required: 127 and -128, or 127 and 0 with `FC_COLLECT_RELU_EN` defined.
- Masking:
  - Stimulus: mask 1010.
  - Required: exactly two beats, on col 0 then col 2; `res_last` is set on col 2.
  - Stimulus: mask 1111.
  - Required: no beat, and `busy` stays 0.
- Backpressure:
  - Stimulus: hold `res_ready`=0 for 5 cycles on col 0.
  - Required: `res_data`, `res_col` and `res_last` are stable for all 5 cycles; the stream then completes with no beat lost or duplicated.
- Overrun:
  - Stimulus: pulse `done` during EMIT, and again on the final handshake edge.
  - Required: holding data is unchanged, `drop_err`=1 and stays 1, and the next `done` in IDLE is accepted.
- Reset:
  - Stimulus: deassert `rst_fsm` (drive 0) asynchronously mid-EMIT.
  - Required: `res_valid`, `busy` and `drop_err` go to 0 without waiting for a clock edge; after release, the block starts in IDLE.
